// File: rtl/hack_mem_pkg.sv
// Shared memory-side types for the RAM port arbiter: default widths, the owner tag,
// the issue-stage state encoding and a generic memory request record.
package hack_mem_pkg;

  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

  // Which requester owns the access currently presented to the RAM.
  function automatic owner_e owner_of(input state_e s);
    case (s)
      BUSY0:   return OWN_P0;
      BUSY1:   return OWN_P1;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Counts consecutive cycles in which port 1 asked but port 0 won; once the count
// reaches STARVE_LIMIT, force_p1 hands the next cycle to port 1.
module ram_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic p1_req,
  input  logic p0_gnt,
  input  logic p1_gnt,
  output logic force_p1
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // Any break in port 1's demand, or a win by port 1, restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!p1_req || p1_gnt) begin
      starve_cnt <= '0;
    end else if (p0_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_p1 = (starve_cnt == LIMIT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one clocked single-port RAM between a fixed-priority CPU port (p0) and a
// DMA/scanner port (p1), issuing at most one access per cycle.
module ram_port_arbiter #(
  parameter int ADDR_W       = hack_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W       = hack_mem_pkg::DEF_DATA_W,
  parameter int STARVE_LIMIT = hack_mem_pkg::DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out
);

  import hack_mem_pkg::*;

  logic   force_p1;
  state_e state;
  logic   issue_rd;
  owner_e rsp_own;

  ram_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .p1_req  (p1_req),
    .p0_gnt  (p0_gnt),
    .p1_gnt  (p1_gnt),
    .force_p1(force_p1)
  );

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      if (force_p1 && p1_req) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  // Stage 1 (state/issue_rd) tags the access the RAM sees now; stage 2 (rsp_own)
  // tags the cycle its read data appears on ram_out. Reset empties both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      issue_rd    <= 1'b0;
      rsp_own     <= OWN_NONE;
      ram_address <= '0;
      ram_in      <= '0;
      ram_write   <= 1'b0;
    end else begin
      rsp_own <= issue_rd ? owner_of(state) : OWN_NONE;
      if (p0_gnt) begin
        state       <= BUSY0;
        issue_rd    <= !p0_we;
        ram_address <= p0_addr;
        ram_in      <= p0_wdata;
        ram_write   <= p0_we;
      end else if (p1_gnt) begin
        state       <= BUSY1;
        issue_rd    <= !p1_we;
        ram_address <= p1_addr;
        ram_in      <= p1_wdata;
        ram_write   <= p1_we;
      end else begin
        state     <= IDLE;
        issue_rd  <= 1'b0;
        ram_write <= 1'b0;
      end
    end
  end

  // ram_out already comes from the RAM's output register, so it is steered, not re-timed.
  assign p0_rvalid = (rsp_own == OWN_P0);
  assign p1_rvalid = (rsp_own == OWN_P1);
  assign p0_rdata  = p0_rvalid ? ram_out : '0;
  assign p1_rdata  = p1_rvalid ? ram_out : '0;

  a_one_gnt: assert property (@(posedge clk) !(p0_gnt && p1_gnt));
  a_gnt_req: assert property (@(posedge clk) (!p0_gnt || p0_req) && (!p1_gnt || p1_req));

endmodule
